// File: rtl/tt_um_hoene_parallel2serial.sv
// tt_um_hoene_parallel2serial: parallel-to-serial frame transmitter, LSB first
// Parameters: WIDTH bits per frame, DIV clk cycles per transmitted bit (1..255).
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   in_word   parallel word, sampled on an accepted handshake
//   in_valid  in_word is valid
//   in_ready  high while IDLE; a word is accepted when in_valid is also high
//   out_data  serial bit, held for a full bit period, 0 outside SHIFT
//   out_clk   one-cycle shift strobe at the end of each bit period
//   out_store one-cycle latch strobe after the last bit
//   busy      high in every state except IDLE
module tt_um_hoene_parallel2serial #(
  parameter int WIDTH = 30,
  parameter int DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_word,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_data,
  output logic             out_clk,
  output logic             out_store,
  output logic             busy
);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [7:0] LAST_DIV = 8'(DIV - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, STORE} state_t;
  state_t state;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0] bit_cnt;
  logic [7:0] div_cnt;
  logic strobe;
  assign strobe = (state == SHIFT) && (div_cnt == LAST_DIV);
  assign in_ready = state == IDLE;
  assign busy = state != IDLE;
  assign out_clk = strobe;
  assign out_store = state == STORE;
  // out_data only moves on the strobe edge, so it is stable across the whole bit period
  assign out_data = (state == SHIFT) && shreg[0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          shreg <= in_word;
          bit_cnt <= '0;
          div_cnt <= '0;
          state <= SHIFT;
        end
        SHIFT: if (strobe) begin
          div_cnt <= '0;
          shreg <= shreg >> 1;
          // bit_cnt wraps on the last bit so it never exceeds WIDTH-1
          bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BW'(1);
          state <= (bit_cnt == LAST_BIT) ? STORE : SHIFT;
        end else begin
          div_cnt <= div_cnt + 8'd1;
        end
        STORE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tt_um_hoene_parallel2serial.sv
// tb_tt_um_hoene_parallel2serial: directed bench for the serializer at DIV 4, 1, 2 and 7
module tb_tt_um_hoene_parallel2serial;
  logic clk, rst_n;
  logic [29:0] word [4];
  logic v [4];
  logic rdy [4], odata [4], oclk [4], ostore [4], obusy [4];
  int total = 0, fails = 0, overlap = 0, stores0 = 0;
  logic [29:0] rx, rxo;

  tt_um_hoene_parallel2serial #(.WIDTH(30), .DIV(4)) u0 (.clk(clk), .rst_n(rst_n), .in_word(word[0]), .in_valid(v[0]),
    .in_ready(rdy[0]), .out_data(odata[0]), .out_clk(oclk[0]), .out_store(ostore[0]), .busy(obusy[0]));
  tt_um_hoene_parallel2serial #(.WIDTH(30), .DIV(1)) u1 (.clk(clk), .rst_n(rst_n), .in_word(word[1]), .in_valid(v[1]),
    .in_ready(rdy[1]), .out_data(odata[1]), .out_clk(oclk[1]), .out_store(ostore[1]), .busy(obusy[1]));
  tt_um_hoene_parallel2serial #(.WIDTH(30), .DIV(2)) u2 (.clk(clk), .rst_n(rst_n), .in_word(word[2]), .in_valid(v[2]),
    .in_ready(rdy[2]), .out_data(odata[2]), .out_clk(oclk[2]), .out_store(ostore[2]), .busy(obusy[2]));
  tt_um_hoene_parallel2serial #(.WIDTH(30), .DIV(7)) u3 (.clk(clk), .rst_n(rst_n), .in_word(word[3]), .in_valid(v[3]),
    .in_ready(rdy[3]), .out_data(odata[3]), .out_clk(oclk[3]), .out_store(ostore[3]), .busy(obusy[3]));

  initial clk = 0;
  always #5 clk = ~clk;

  // receiver on the DIV=1 instance: right shift inserting at the MSB, latch on store
  always @(posedge clk) begin
    if (oclk[1]) rx <= {odata[1], rx[29:1]};
    if (ostore[1]) rxo <= rx;
    if (ostore[0]) stores0 <= stores0 + 1;
  end

  always @(negedge clk)
    if ((oclk[0] && ostore[0]) || (oclk[1] && ostore[1]) || (oclk[2] && ostore[2]) || (oclk[3] && ostore[3]))
      overlap <= overlap + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input int i);
    chk($sformatf("rst i%0d ready", i), 32'(rdy[i]), 1);
    chk($sformatf("rst i%0d data", i), 32'(odata[i]), 0);
    chk($sformatf("rst i%0d clk", i), 32'(oclk[i]), 0);
    chk($sformatf("rst i%0d store", i), 32'(ostore[i]), 0);
    chk($sformatf("rst i%0d busy", i), 32'(obusy[i]), 0);
  endtask

  // caller sits in cycle 0 with in_valid high; handshake happens at the next edge
  task automatic frame(input int i, input int d, input logic [29:0] w, input bit hold, input logic [29:0] nxt);
    int n = 0;
    for (int c = 1; c <= 30*d + 2; c++) begin
      tick();
      if (c == 1) begin
        v[i] = hold;
        word[i] = ~w;
      end
      if (c == 30*d) word[i] = nxt;
      n += int'(oclk[i]);
      chk($sformatf("i%0d c%0d clk", i, c), 32'(oclk[i]), 32'((c % d == 0) && (c <= 30*d)));
      chk($sformatf("i%0d c%0d data", i, c), 32'(odata[i]), (c <= 30*d) ? 32'(w[(c-1)/d]) : 0);
      chk($sformatf("i%0d c%0d store", i, c), 32'(ostore[i]), 32'(c == 30*d + 1));
      chk($sformatf("i%0d c%0d ready", i, c), 32'(rdy[i]), 32'(c == 30*d + 2));
      chk($sformatf("i%0d c%0d busy", i, c), 32'(obusy[i]), 32'(c != 30*d + 2));
    end
    chk($sformatf("i%0d strobes", i), 32'(n), 30);
  endtask

  initial begin
    logic [29:0] lw [3];
    int s;
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      v[i] = 0;
      word[i] = '0;
    end
    #2 rst_n = 0;
    #1;
    for (int i = 0; i < 4; i++) chk_reset(i);
    tick();
    tick();
    rst_n = 1;
    tick();
    word[0] = 30'h2AAAAAAA;
    v[0] = 1;
    frame(0, 4, 30'h2AAAAAAA, 0, 30'h0);
    word[0] = 30'h12345678;
    v[0] = 1;
    frame(0, 4, 30'h12345678, 1, 30'h0F0F1234);
    frame(0, 4, 30'h0F0F1234, 0, 30'h3FFFFFFF);
    lw[0] = 30'h3FFFFFFF;
    lw[1] = 30'h00000001;
    lw[2] = 30'h20000000;
    for (int k = 0; k < 3; k++) begin
      word[1] = lw[k];
      v[1] = 1;
      frame(1, 1, lw[k], 0, 30'h0);
      chk($sformatf("loopback %0d", k), 32'(rxo), 32'(lw[k]));
    end
    for (int i = 1; i < 4; i++)
      for (int k = 0; k < 2; k++) begin
        logic [29:0] r;
        r = 30'($urandom);
        word[i] = r;
        v[i] = 1;
        frame(i, (i == 1) ? 1 : (i == 2) ? 2 : 7, r, 0, 30'($urandom));
      end
    word[0] = 30'h155AA3C3;
    v[0] = 1;
    tick();
    v[0] = 0;
    for (int c = 2; c <= 50; c++) tick();
    chk("mid busy", 32'(obusy[0]), 1);
    s = stores0;
    #2 rst_n = 0;
    #1;
    chk_reset(0);
    tick();
    tick();
    chk_reset(0);
    chk("abort store", 32'(stores0), 32'(s));
    word[0] = 30'h0C0FFEE5;
    v[0] = 1;
    rst_n = 1;
    frame(0, 4, 30'h0C0FFEE5, 0, 30'h0);
    chk("overlap", 32'(overlap), 0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/tt_um_hoene_parallel2serial.md
TT_UM_HOENE_PARALLEL2SERIAL -- requirements
Module: tt_um_hoene_parallel2serial

Interface
REQ-001 Parameter WIDTH, default 30: bits per frame.
REQ-002 Parameter DIV, default 4, legal range 1..255: clk cycles per transmitted bit.
REQ-003 clk  input  1  global clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_word  input  WIDTH  parallel word to transmit; sampled only on an accepted handshake.
REQ-006 in_valid  input  1  in_word is valid.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 out_data  output  1  serial data bit; drives the receiver's in_data.
REQ-009 out_clk  output  1  one-cycle shift strobe; drives the receiver's in_clk.
REQ-010 out_store  output  1  one-cycle latch strobe; drives the receiver's store.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 FSM states SHALL be IDLE, SHIFT and STORE.
REQ-013 in_ready SHALL equal (state == IDLE), with no combinational path from in_valid.
REQ-014 Handshake: when in_valid && in_ready at a rising edge:
  - in_word loads into the shift register;
  - bit_cnt and div_cnt clear to 0;
  - FSM enters SHIFT.
REQ-015 In SHIFT, div_cnt SHALL count 0..DIV-1 and wrap to 0.
REQ-016 out_clk SHALL be 1 exactly when the FSM is in SHIFT and div_cnt == DIV-1; it SHALL be 0 otherwise.
REQ-017 out_data SHALL equal shift_register[0] in SHIFT and 0 in every other state.
REQ-018 out_data SHALL be stable for all DIV cycles of a bit period, including the strobe cycle.
REQ-019 On each strobe edge, the shift register SHALL shift right by one and bit_cnt SHALL increment, so bits leave LSB first.
REQ-020 The word SHALL arrive unchanged at a right-shifting receiver that inserts at its MSB.
REQ-021 On the strobe edge where bit_cnt == WIDTH-1, the FSM SHALL go SHIFT -> STORE. Exactly WIDTH strobes occur per frame.
REQ-022 STORE SHALL last exactly one cycle, with out_store = 1; the FSM then returns to IDLE.
REQ-023 Timing, with the handshake edge as cycle 0:
  - strobe k (k = 0..WIDTH-1) is high in cycle (k+1)*DIV;
  - out_store is high in cycle WIDTH*DIV+1;
  - in_ready is high again in cycle WIDTH*DIV+2.
REQ-024 While busy, changes on in_word and in_valid SHALL have no effect.
REQ-025 A word presented with in_valid held high SHALL be accepted on the first IDLE cycle. Back-to-back frames SHALL have exactly one IDLE cycle between them.
REQ-026 With DIV == 1, out_clk SHALL be high on every SHIFT cycle. out_data SHALL still change only after each strobe edge.
REQ-027 bit_cnt SHALL be ceil(log2(WIDTH)) bits wide and SHALL never exceed WIDTH-1. div_cnt SHALL be 8 bits wide.
REQ-028 out_clk and out_store SHALL never be high in the same cycle.

Reset
REQ-029 While rst_n = 0, the following SHALL hold immediately, without waiting for a clock:
  - FSM = IDLE;
  - shift register, bit_cnt and div_cnt = 0;
  - out_data, out_clk, out_store and busy = 0;
  - in_ready = 1.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no out_store pulse. The first edge after deassertion SHALL accept a new word if in_valid = 1.

Verification
REQ-031 DIV=4, in_word=0x2AAAAAAA, in_valid pulsed one cycle:
  - strobes in cycles 4, 8, ..., 120;
  - out_data at the strobes reads 0,1,0,1,...;
  - out_store in cycle 121; in_ready in cycle 122.
REQ-032 Loopback into the existing receiver, DIV=1, words 0x3FFFFFFF, 0x00000001 and 0x20000000: the receiver's output_data SHALL equal each word after its out_store.
REQ-033 in_valid held high with two words queued: second handshake at cycle WIDTH*DIV+2; exactly one IDLE cycle between frames; in_word changes during a frame have no effect.
REQ-034 rst_n pulled low at cycle 50 of a DIV=4 frame: all outputs 0 and in_ready 1 asynchronously; no out_store; a new word is accepted on the first edge after release.
REQ-035 Over random words and DIV in {1,2,7}: out_clk count per frame == WIDTH, exactly one out_store per frame, and out_clk and out_store never high together.
